// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_LD_MISALIGN = 2'd0;
    localparam logic [1:0] CAUSE_ST_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering, load extraction and legality checks
module lsu_align
    import lsu_pkg::*;
(
    input  logic        chk_store,
    input  logic [2:0]  chk_funct3,
    input  logic [31:0] chk_addr,
    input  logic [31:0] chk_wdata,
    output logic        chk_illegal,
    output logic        chk_misaligned,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        if (chk_store) begin
            chk_illegal = (chk_funct3 >= 3'b011);
        end else begin
            chk_illegal = (chk_funct3 == 3'b011) || (chk_funct3 == 3'b110) || (chk_funct3 == 3'b111);
        end
        chk_misaligned = ((chk_funct3[1:0] == 2'b01) && chk_addr[0]) ||
                         ((chk_funct3[1:0] == 2'b10) && (chk_addr[1:0] != 2'b00));

        // Replicate narrow stores across lanes; strobes pick the live one
        case (chk_funct3[1:0])
            2'b00: begin
                st_wdata = {4{chk_wdata[7:0]}};
                st_wstrb = 4'b0001 << chk_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{chk_wdata[15:0]}};
                st_wstrb = chk_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = chk_wdata;
                st_wstrb = 4'b1111;
            end
        endcase
        if (!chk_store) begin
            st_wstrb = 4'b0000;
        end
    end

    always_comb begin
        ld_shift = ld_rdata >> {ld_addr, 3'b000};
        ld_byte  = ld_shift[7:0];
        ld_half  = ld_addr[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding RV32I load/store unit
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        st_done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr
);

    state_t      state, state_nx;
    logic        accept;
    logic        chk_illegal, chk_misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        store_q;
    logic [4:0]  rd_q;

    lsu_align u_align (
        .chk_store      (req_store),
        .chk_funct3     (req_funct3),
        .chk_addr       (req_addr),
        .chk_wdata      (req_wdata),
        .chk_illegal    (chk_illegal),
        .chk_misaligned (chk_misaligned),
        .st_wdata       (st_wdata),
        .st_wstrb       (st_wstrb),
        .ld_funct3      (funct3_q),
        .ld_addr        (addr_q[1:0]),
        .ld_rdata       (mem_rdata),
        .ld_data        (ld_data)
    );

    assign accept   = req_valid & req_ready;
    assign mem_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        mem_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept && !chk_illegal && !chk_misaligned) begin
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    state_nx = store_q ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            store_q     <= 1'b0;
            rd_q        <= '0;
            mem_we      <= 1'b0;
            mem_wstrb   <= '0;
            mem_wdata   <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            st_done     <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= '0;
            fault_addr  <= '0;
        end else begin
            state    <= state_nx;
            wb_valid <= 1'b0;
            st_done  <= 1'b0;
            fault    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (chk_illegal || chk_misaligned) begin
                            fault       <= 1'b1;
                            fault_addr  <= req_addr;
                            fault_cause <= chk_illegal ? CAUSE_ILLEGAL :
                                           (req_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN);
                        end else begin
                            addr_q    <= req_addr;
                            funct3_q  <= req_funct3;
                            store_q   <= req_store;
                            rd_q      <= req_rd;
                            mem_we    <= req_store;
                            mem_wstrb <= st_wstrb;
                            mem_wdata <= st_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        st_done   <= store_q;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= ld_data;
                        wb_rd    <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_done;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_addr;

    int n_vec = 0;
    int n_err = 0;

    lsu dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .st_done     (st_done),
        .fault       (fault),
        .fault_cause (fault_cause),
        .fault_addr  (fault_addr)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
    endtask

    // Zero-wait load: accept cycle 0, request cycle 1, rvalid cycle 2, writeback cycle 3
    task automatic zw_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
        cyc(); issue(1'b0, f3, a, 32'h0, rd); mem_ready = 1'b1;
        cyc(); req_valid = 1'b0;
        mid(); chk({tag, "_mem_valid"}, {31'h0, mem_valid}, 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
        cyc(); mem_rvalid = 1'b1; mem_rdata = rdata;
        cyc(); mem_rvalid = 1'b0;
        mid(); chk({tag, "_wb_valid"}, {31'h0, wb_valid}, 32'd1);
        chk({tag, "_wb_data"}, wb_data, exp);
        chk({tag, "_wb_rd"}, {27'h0, wb_rd}, {27'h0, rd});
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        cyc(); cyc();
        mid();
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_pulses", {29'h0, wb_valid, st_done, fault}, 32'h0);
        cyc(); rst = 1'b0;

        // LW with exact latency checks
        cyc(); issue(1'b0, F3W(), 32'h100, 32'h0, 5'd5); mem_ready = 1'b1;
        mid(); chk("lw_c0_mem_valid", {31'h0, mem_valid}, 32'd0);
        cyc(); req_valid = 1'b0;
        mid(); chk("lw_c1_mem_valid", {31'h0, mem_valid}, 32'd1);
        chk("lw_c1_mem_addr", mem_addr, 32'h100);
        chk("lw_c1_we_strb", {27'h0, mem_we, mem_wstrb}, 32'h0);
        chk("lw_c1_req_ready", {31'h0, req_ready}, 32'd0);
        cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        mid(); chk("lw_c2_wb_valid", {31'h0, wb_valid}, 32'd0);
        cyc(); mem_rvalid = 1'b0; mem_rdata = 32'h0;
        mid(); chk("lw_c3_wb_valid", {31'h0, wb_valid}, 32'd1);
        chk("lw_c3_wb_data", wb_data, 32'hDEADBEEF);
        chk("lw_c3_wb_rd", {27'h0, wb_rd}, 32'd5);
        cyc();
        mid(); chk("lw_c4_wb_valid", {31'h0, wb_valid}, 32'd0);
        chk("lw_c4_wb_hold", wb_data, 32'hDEADBEEF);

        zw_load("lb", 3'b000, 32'h103, 5'd6, 32'h80FF1122, 32'hFFFFFF80);
        zw_load("lbu", 3'b100, 32'h103, 5'd7, 32'h80FF1122, 32'h00000080);
        zw_load("lhu", 3'b101, 32'h102, 5'd8, 32'h80FF1122, 32'h000080FF);
        zw_load("lh", 3'b001, 32'h102, 5'd9, 32'h80FF1122, 32'hFFFF80FF);
        zw_load("lb0", 3'b000, 32'h104, 5'd10, 32'h80FF1122, 32'h00000022);

        // SH store lane steering
        cyc(); issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0);
        cyc(); req_valid = 1'b0;
        mid(); chk("sh_mem_valid", {31'h0, mem_valid}, 32'd1);
        chk("sh_mem_addr", mem_addr, 32'h200);
        chk("sh_we", {31'h0, mem_we}, 32'd1);
        chk("sh_wstrb", {28'h0, mem_wstrb}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'hABCDABCD);
        cyc();
        mid(); chk("sh_st_done", {31'h0, st_done}, 32'd1);
        chk("sh_mem_valid_drop", {31'h0, mem_valid}, 32'd0);
        cyc();
        mid(); chk("sh_st_done_pulse", {31'h0, st_done}, 32'd0);

        // SB at byte 1
        cyc(); issue(1'b1, 3'b000, 32'h301, 32'h000000A5, 5'd0);
        cyc(); req_valid = 1'b0;
        mid(); chk("sb_wstrb", {28'h0, mem_wstrb}, 32'h2);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        cyc(); cyc();

        // Misaligned LW
        cyc(); issue(1'b0, 3'b010, 32'h101, 32'h0, 5'd1);
        cyc(); req_valid = 1'b0;
        mid(); chk("mis_lw_fault", {31'h0, fault}, 32'd1);
        chk("mis_lw_cause", {30'h0, fault_cause}, 32'd0);
        chk("mis_lw_addr", fault_addr, 32'h101);
        chk("mis_lw_mem_valid", {31'h0, mem_valid}, 32'd0);
        chk("mis_lw_req_ready", {31'h0, req_ready}, 32'd1);
        cyc();
        mid(); chk("mis_lw_fault_pulse", {31'h0, fault}, 32'd0);
        chk("mis_lw_mem_valid2", {31'h0, mem_valid}, 32'd0);

        // Illegal load funct3
        cyc(); issue(1'b0, 3'b111, 32'h100, 32'h0, 5'd1);
        cyc(); req_valid = 1'b0;
        mid(); chk("ill_ld_fault", {31'h0, fault}, 32'd1);
        chk("ill_ld_cause", {30'h0, fault_cause}, 32'd2);
        chk("ill_ld_mem_valid", {31'h0, mem_valid}, 32'd0);

        // Misaligned SH store
        cyc(); issue(1'b1, 3'b001, 32'h203, 32'h0, 5'd0);
        cyc(); req_valid = 1'b0;
        mid(); chk("mis_sh_cause", {29'h0, fault, fault_cause}, 32'h5);
        chk("mis_sh_addr", fault_addr, 32'h203);

        // Illegal store funct3
        cyc(); issue(1'b1, 3'b011, 32'h200, 32'h0, 5'd0);
        cyc(); req_valid = 1'b0;
        mid(); chk("ill_st_cause", {29'h0, fault, fault_cause}, 32'h6);

        // Back-pressure: mem_ready low 4 cycles, rvalid 3 cycles late
        cyc(); issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd12); mem_ready = 1'b0;
        cyc(); req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("bp_mem_valid", {31'h0, mem_valid}, 32'd1);
            chk("bp_mem_addr", mem_addr, 32'h300);
            chk("bp_req_ready", {31'h0, req_ready}, 32'd0);
            cyc();
        end
        mem_ready = 1'b1;
        cyc(); mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("late_wb_valid", {31'h0, wb_valid}, 32'd0);
            chk("late_req_ready", {31'h0, req_ready}, 32'd0);
            cyc();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        cyc(); mem_rvalid = 1'b0;
        mid(); chk("late_wb_valid_hi", {31'h0, wb_valid}, 32'd1);
        chk("late_wb_data", wb_data, 32'h0BADF00D);
        cyc();
        mid(); chk("late_wb_single", {31'h0, wb_valid}, 32'd0);

        // Reset while waiting for read data, then a stale rvalid
        cyc(); issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd3); mem_ready = 1'b1;
        cyc(); req_valid = 1'b0;
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        mid(); chk("rst_wait_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_wait_mem_valid", {31'h0, mem_valid}, 32'd0);
        chk("rst_wait_wb_valid", {31'h0, wb_valid}, 32'd0);
        cyc(); mem_rvalid = 1'b0;
        mid(); chk("stale_rvalid_wb", {31'h0, wb_valid}, 32'd0);
        chk("stale_rvalid_data", wb_data, 32'h0);

        // Unit still works after reset
        zw_load("post_rst", 3'b010, 32'h500, 5'd4, 32'hCAFEF00D, 32'hCAFEF00D);

        cyc(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic [2:0] F3W();
        return 3'b010;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
